// File: rtl/mux_rr_arbiter.sv
// Round-robin select sequencer for a 16:1 bit mux with registered output.
// Optional forced release after MAX_HOLD cycles: define ARB_HOLD_LIMIT_EN.
module mux_rr_arbiter #(
  parameter int N        = 16,
  parameter int SW       = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  in,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] sel,
  output logic          out,
  output logic          out_valid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] REL   = 2'd2;

  if (N != (1 << SW)) begin : g_bad_n
    $error("N must equal 2**SW");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD out of range 1..255");
  end

  logic [1:0]    state;
  logic [SW-1:0] last;
  logic [SW-1:0] pick;
  logic [SW-1:0] idx;
  logic          found;
  logic          rel_now;

  // First set request scanning upward from last+1, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = last + SW'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0] hold_cnt;
  logic       others;

  // Count granted cycles, saturating; cleared while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else if (state == GRANT && hold_cnt != 8'hff) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  // Release on dropped request, or on hold limit when someone waits.
  always_comb begin
    others  = |(req & ~grant);
    rel_now = !req[sel];
    if (others && hold_cnt == 8'(MAX_HOLD - 1)) begin
      rel_now = 1'b1;
    end
  end
`else
  // Release only when the owner drops its request.
  always_comb begin
    rel_now = !req[sel];
  end
`endif

  // Arbitration FSM with registered grant, select and sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= SW'(N - 1);
      grant     <= '0;
      sel       <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (found) begin
            grant <= {{(N-1){1'b0}}, 1'b1} << pick;
            sel   <= pick;
            last  <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          out       <= in[sel];
          out_valid <= 1'b1;
          if (rel_now) begin
            grant <= '0;
            state <= REL;
          end
        end
        REL: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          grant     <= '0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 16:1 bit-select mux datapath among 16 requesters.
- Each requester owns one mux input bit. The block picks one requester at a time, drives the mux select, and streams a registered sample of the selected input to a single output with a valid flag.
- Sits in front of the 16:1 mux datapath and acts as its select sequencer.

Parameters:
- N, 16, number of requesters and mux inputs; must be a power of 2.
- SW, 4, select width; equals log2(N).
- MAX_HOLD, 8, maximum consecutive granted cycles before a forced release. Used only when the optional feature is compiled in. Legal range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  per-requester request. A requester holds its bit high for as long as it wants the mux.
- in  input  N  mux data inputs; bit i belongs to requester i.
- grant  output  N  one-hot grant, registered; all zeros when nothing is granted.
- sel  output  SW  mux select, registered; equals the index of the granted requester.
- out  output  1  registered sample of in[sel].
- out_valid  output  1  high when out carries a sample taken under an active grant.

Behaviour:
- Reset (async, immediate, also mid-grant):
  - grant=0, sel=0, out=0, out_valid=0.
  - State=IDLE, pointer last=N-1, so the first search starts at index 0.
  - hold_cnt=0.
- States: IDLE, GRANT, REL.
- IDLE:
  - If req!=0, pick the first set req bit scanning last+1, last+2, ... and wrapping modulo N.
  - Next edge: grant=onehot(idx), sel=idx, last=idx, hold_cnt=0, state=GRANT.
  - Latency from req sampled high to grant high is 1 cycle.
  - If req==0, stay in IDLE.
- GRANT, each cycle:
  - out<=in[sel], out_valid<=1, hold_cnt increments, saturating at 255.
  - If req[sel]==0 at the edge, go to REL: grant<=0, and sel keeps its value.
- REL (exactly one cycle):
  - grant=0, out_valid<=0, out holds its last value.
  - Next state=IDLE.
  - Arbitration happens in IDLE, so the minimum gap between grants is 2 cycles with grant=0.
- out/out_valid timing:
  - out and out_valid lag grant by 1 cycle.
  - The first valid sample appears the cycle after grant rises.
  - The last valid sample appears the cycle grant falls.
- Fairness:
  - The pointer always moves to the last granted index.
  - A requester that keeps req high is served at most once per full rotation while others are waiting.
- Simultaneous events:
  - If req[sel] drops in the same cycle another req rises, the new request waits for REL→IDLE.
  - If the granted requester re-raises req in REL, it is treated as a new request and ranks last in the rotation.
- Glitches: a req bit that pulses low and high while in IDLE is sampled only at the clock edge.
- grant is always one-hot or zero. sel never changes while in GRANT.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- Defined:
  - In GRANT, when hold_cnt==MAX_HOLD-1 and at least one other req bit is set, force GRANT→REL even though req[sel] is still high.
  - If no other request is pending, the grant continues and hold_cnt saturates.
  - After the forced release, the round-robin pointer guarantees the next grant goes to a different requester whenever one is waiting.
- Undefined:
  - A grant lasts until its req drops; MAX_HOLD is ignored.
  - hold_cnt logic may be removed from the build.

Test Plan:
- Reset then single request: rst pulse, then req=16'h0004 held → grant=16'h0004 and sel=2 one cycle later. out_valid=1 the following cycle, and out tracks in[2] with a 1-cycle lag.
- Round-robin order: req=16'h8001 held, each requester drops req after 3 granted cycles and re-raises it in REL → grant sequence 0,15,0,15, with exactly 2 grant-low cycles between grants.
- Wrap-around: force last=14 by serving requester 14, then req=16'h0003|16'h4000 → next grant index 0, then 1, then 14.
- Async reset mid-grant: assert rst while grant=16'h0100 → grant, sel, out and out_valid go to 0 immediately without waiting for a clock edge. After release with req=16'h0100, grant returns 1 cycle later at index 8.
- Hold limit (ARB_HOLD_LIMIT_EN, MAX_HOLD=8): req=16'h0011 held → requester 0 gets exactly 8 grant cycles, REL, IDLE, then requester 4 gets 8 cycles.
- No-competition hold (ARB_HOLD_LIMIT_EN): req=16'h0020 held for 300 cycles → grant stays continuously at index 5, and out_valid stays high once asserted.
